vliw_fetch: RTL

- Front-end fetch unit producing the instruction bundle and bundle PC consumed by the slot pipelines (branch, ALU, memory).
- Closes the loop on the branch pipe's redirect: consumes branch_taken/new_pc, squashes the wrong-path bundle in the decode register and discards in-flight wrong-path memory responses.
- Talks to instruction memory over an in-order request/response interface with variable latency; a small bundle queue absorbs pipeline stall.

---
 rtl/vliw_fetch_if.sv | 27 ++
 rtl/vliw_fetch.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/vliw_fetch_if.sv
// vliw_fetch_if: in-order instruction memory request/response bus.
// master = fetch unit, slave = instruction memory.
interface vliw_fetch_if #(
    parameter int unsigned SLOTS = 4
);
    logic                  imem_req;
    logic [31:0]           imem_addr;
    logic                  imem_ready;
    logic                  imem_rvalid;
    logic [SLOTS*32-1:0]   imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/vliw_fetch.sv
// vliw_fetch: bundle fetch front end with redirect squash and bundle queue.
// Define FETCH_PERF_EN to add the perf_bundles/perf_squashed/perf_starve counters.
module vliw_fetch #(
    parameter int unsigned SLOTS     = 4,
    parameter int unsigned BUF_DEPTH = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INST  = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [31:0]         new_pc,
    vliw_fetch_if.master        imem,
    output logic [SLOTS*32-1:0] inst,
    output logic [31:0]         inst_pc,
    output logic                inst_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]         perf_bundles,
    output logic [31:0]         perf_squashed,
    output logic [31:0]         perf_starve
`endif
);
    typedef enum logic [1:0] {BOOT, FETCH, DRAIN} state_t;

    localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
    localparam int unsigned PW = $clog2(BUF_DEPTH);
    localparam logic [31:0] STEP = 32'(SLOTS * 4);
    localparam logic [31:0] AMASK = ~(STEP - 32'd1);
    localparam logic [PW-1:0] P1 = PW'(1);
    localparam logic [CW:0] DEPTH_C = BUF_DEPTH[CW:0];
    localparam logic [SLOTS*32-1:0] NOP_BUNDLE = {SLOTS{NOP_INST}};

    state_t              state;
    logic [31:0]         pc;
    logic [CW-1:0]       q_cnt;
    logic [CW-1:0]       outstanding;
    logic [CW-1:0]       drop_cnt;
    logic [CW-1:0]       drop_next;
    logic [PW-1:0]       q_rd, q_wr, t_rd, t_wr;
    logic [SLOTS*32-1:0] q_data [BUF_DEPTH];
    logic [31:0]         q_pc   [BUF_DEPTH];
    logic [31:0]         t_pc   [BUF_DEPTH];
    logic [CW:0]         occ;
    logic                req, xfer, resp, drop, push, pop;

    always_comb begin
        occ  = {1'b0, q_cnt} + {1'b0, outstanding};
        req  = (state != BOOT) && !branch_taken && (occ < DEPTH_C);
        xfer = req && imem.imem_ready;
        resp = imem.imem_rvalid && (outstanding != '0);
        drop = resp && (drop_cnt != '0);
        push = resp && !drop && !branch_taken;
        pop  = !branch_taken && !stall && (q_cnt != '0);
        // a redirect dooms everything in flight except a response landing now
        drop_next = branch_taken ? outstanding - CW'(resp)
                                 : drop_cnt - CW'(drop);
    end

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc;

    always_ff @(posedge clk) begin
        if (push) begin
            q_data[q_wr] <= imem.imem_rdata;
            q_pc[q_wr]   <= t_pc[t_rd];
        end
        if (xfer) t_pc[t_wr] <= pc;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            q_cnt       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            q_rd        <= '0;
            q_wr        <= '0;
            t_rd        <= '0;
            t_wr        <= '0;
            inst        <= NOP_BUNDLE;
            inst_pc     <= '0;
            inst_valid  <= 1'b0;
        end else begin
            outstanding <= outstanding + CW'(xfer) - CW'(resp);
            drop_cnt    <= drop_next;
            if (xfer) pc <= pc + STEP;

            unique case (state)
                BOOT:  state <= FETCH;
                FETCH: if (branch_taken && drop_next != '0) state <= DRAIN;
                DRAIN: if (!branch_taken && drop_next == '0) state <= FETCH;
                default: state <= BOOT;
            endcase

            if (branch_taken) begin
                pc         <= new_pc & AMASK;
                q_cnt      <= '0;
                q_rd       <= '0;
                q_wr       <= '0;
                t_rd       <= '0;
                t_wr       <= '0;
                inst       <= NOP_BUNDLE;
                inst_valid <= 1'b0;
            end else begin
                if (xfer) t_wr <= t_wr + P1;
                if (push) begin
                    q_wr <= q_wr + P1;
                    t_rd <= t_rd + P1;
                end
                if (pop) q_rd <= q_rd + P1;
                q_cnt <= q_cnt + CW'(push) - CW'(pop);
                if (!stall) begin
                    if (q_cnt != '0) begin
                        inst       <= q_data[q_rd];
                        inst_pc    <= q_pc[q_rd];
                        inst_valid <= 1'b1;
                    end else begin
                        inst       <= NOP_BUNDLE;
                        inst_valid <= 1'b0;
                    end
                end
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] squash_now;

    always_comb begin
        squash_now = 32'(drop || (resp && branch_taken));
        if (branch_taken) squash_now = squash_now + 32'(q_cnt) + 32'(inst_valid);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_bundles  <= '0;
            perf_squashed <= '0;
            perf_starve   <= '0;
        end else begin
            perf_bundles  <= perf_bundles + 32'(pop);
            perf_squashed <= perf_squashed + squash_now;
            if (state != BOOT && !stall && q_cnt == '0)
                perf_starve <= perf_starve + 32'd1;
        end
    end
`endif
endmodule
